mem_port_arb: RTL and testbench

- Arbitrates the shared read/write data port (port 1) of the bfX unified memory between two requesters:
  - the core: data-pointer cell reads and writes;
  - the host: program loader / debugger.
- Issues at most one access per cycle and returns read data with the memory's fixed 1-cycle synchronous-read latency.
- Supports a host lock for burst program loads, with a bounded lock length so the core is never starved.
- The instruction-fetch port (port 2) is not touched by this block.

---
 rtl/bfx_mem_pkg.sv | 19 +
 rtl/rr_arb2.sv | 21 ++
 rtl/mem_port_arb.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arb.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfx_mem_pkg.sv
// Shared constants and types for the bfX memory port-1 arbiter.
package bfx_mem_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 512;

    typedef enum logic [1:0] {
        ARB_RR,
        HOST_LOCKED,
        FORCE_CORE
    } arb_state_t;

    typedef enum logic {
        REQ_CORE,
        REQ_HOST
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between core (req[0]) and host (req[1]).
module rr_arb2
    import bfx_mem_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output req_id_t    winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = REQ_CORE;
        if (req == 2'b11) begin
            winner = (last == REQ_CORE) ? REQ_HOST : REQ_CORE;
        end else if (req[1]) begin
            winner = REQ_HOST;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Port-1 arbiter of the bfX unified memory: core vs host, with bounded host lock.
// Optional grant statistics are built when MEM_ARB_STATS_EN is defined.
module mem_port_arb #(
    parameter int ADDR_W    = bfx_mem_pkg::ADDR_W,
    parameter int DATA_W    = bfx_mem_pkg::DATA_W,
    parameter int MEM_DEPTH = bfx_mem_pkg::MEM_DEPTH,
    parameter int MAX_LOCK  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_err,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,
    input  logic              host_lock,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       core_gnt_cnt,
    output logic [15:0]       host_gnt_cnt
);
    import bfx_mem_pkg::*;

    localparam int                LCNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(MAX_LOCK);
    localparam logic [LCNT_W-1:0] LOCK_ONE = LCNT_W'(1);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(MEM_DEPTH);

    arb_state_t        state_q;
    req_id_t           last_q;
    logic [LCNT_W-1:0] lock_cnt_q;

    logic    core_inr, host_inr;
    logic    rr_valid;
    req_id_t rr_winner;
    logic    both_req;
    logic    lock_expired;

    assign core_inr     = {1'b0, core_addr} < DEPTH;
    assign host_inr     = {1'b0, host_addr} < DEPTH;
    assign both_req     = core_req & host_req;
    assign lock_expired = (lock_cnt_q == LOCK_MAX) && core_req;

    rr_arb2 u_rr (
        .req    ({host_req, core_req}),
        .last   (last_q),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    // Grant decision: combinational from registered state and live requests.
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        unique case (state_q)
            HOST_LOCKED: begin
                if (!host_lock) begin
                    core_gnt = rr_valid && (rr_winner == REQ_CORE);
                    host_gnt = rr_valid && (rr_winner == REQ_HOST);
                end else if (!lock_expired) begin
                    host_gnt = host_req;
                end
            end
            FORCE_CORE: core_gnt = core_req;
            default: begin
                core_gnt = rr_valid && (rr_winner == REQ_CORE);
                host_gnt = rr_valid && (rr_winner == REQ_HOST);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_RR;
            last_q     <= REQ_HOST;
            lock_cnt_q <= '0;
        end else begin
            unique case (state_q)
                HOST_LOCKED: begin
                    if (!host_lock) begin
                        state_q    <= ARB_RR;
                        lock_cnt_q <= '0;
                        if (both_req) last_q <= rr_winner;
                    end else if (lock_expired) begin
                        state_q <= FORCE_CORE;
                    end else if (lock_cnt_q != LOCK_MAX) begin
                        lock_cnt_q <= lock_cnt_q + LOCK_ONE;
                    end
                end
                FORCE_CORE: begin
                    lock_cnt_q <= '0;
                    state_q    <= host_lock ? HOST_LOCKED : ARB_RR;
                end
                default: begin
                    if (both_req) last_q <= rr_winner;
                    if (host_gnt && host_lock) begin
                        state_q    <= HOST_LOCKED;
                        lock_cnt_q <= LOCK_ONE;
                    end
                end
            endcase
        end
    end

    logic              gnt_any;
    logic              sel_we, sel_inr;
    logic [ADDR_W-1:0] sel_addr, mem_addr_q;
    logic [DATA_W-1:0] sel_wdata, mem_wdata_q;

    assign gnt_any   = core_gnt | host_gnt;
    assign sel_we    = host_gnt ? host_we    : core_we;
    assign sel_inr   = host_gnt ? host_inr   : core_inr;
    assign sel_addr  = host_gnt ? host_addr  : core_addr;
    assign sel_wdata = host_gnt ? host_wdata : core_wdata;

    // The memory bus parks on the last granted access when idle.
    always_ff @(posedge clk) begin
        if (gnt_any) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
        end
    end

    assign mem_addr  = gnt_any ? sel_addr  : mem_addr_q;
    assign mem_wdata = gnt_any ? sel_wdata : mem_wdata_q;
    assign mem_we    = gnt_any & sel_we & sel_inr;

    logic core_rvld_q, core_err_q, host_rvld_q, host_err_q;

    // Response stage: one cycle behind the grant, matching the memory read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rvld_q <= 1'b0;
            core_err_q  <= 1'b0;
            host_rvld_q <= 1'b0;
            host_err_q  <= 1'b0;
        end else begin
            core_rvld_q <= core_gnt & ~core_we;
            core_err_q  <= core_gnt & ~core_inr;
            host_rvld_q <= host_gnt & ~host_we;
            host_err_q  <= host_gnt & ~host_inr;
        end
    end

    assign core_rvalid = core_rvld_q;
    assign core_err    = core_err_q;
    assign core_rdata  = (core_rvld_q && !core_err_q) ? mem_rdata : '0;
    assign host_rvalid = host_rvld_q;
    assign host_err    = host_err_q;
    assign host_rdata  = (host_rvld_q && !host_err_q) ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] core_cnt_q, host_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            core_cnt_q <= '0;
            host_cnt_q <= '0;
        end else begin
            if (core_gnt && core_cnt_q != 16'hFFFF) core_cnt_q <= core_cnt_q + 16'd1;
            if (host_gnt && host_cnt_q != 16'hFFFF) host_cnt_q <= host_cnt_q + 16'd1;
        end
    end

    assign core_gnt_cnt = core_cnt_q;
    assign host_gnt_cnt = host_cnt_q;
`else
    assign core_gnt_cnt = '0;
    assign host_gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed vector table, reset corner case, randomized run vs model.
module tb_mem_port_arb;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 512;
    localparam int MAXL  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, host_req, host_we, host_lock;
    logic [AW-1:0] core_addr, host_addr;
    logic [DW-1:0] core_wdata, host_wdata;
    logic          core_gnt, core_rvalid, core_err, host_gnt, host_rvalid, host_err;
    logic [DW-1:0] core_rdata, host_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   core_gnt_cnt, host_gnt_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
        .host_lock(host_lock),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_gnt_cnt(core_gnt_cnt), .host_gnt_cnt(host_gnt_cnt)
    );

    function automatic logic [7:0] init_val(input int a);
        return (a == 0) ? 8'h2B : 8'((a * 7 + 3) & 255);
    endfunction

    function automatic bit inr(input logic [15:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Memory: 1-cycle synchronous read, write-first; stored as XOR delta from the preload.
    bit [7:0] delta [0:65535];
    always @(posedge clk) begin
        if (mem_we) delta[mem_addr] <= mem_wdata ^ init_val(int'(mem_addr));
        mem_rdata <= mem_we ? mem_wdata : (init_val(int'(mem_addr)) ^ delta[mem_addr]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic set_in(input logic creq, input logic cwe, input logic [15:0] caddr, input logic [7:0] cwd,
                          input logic hreq, input logic hwe, input logic [15:0] haddr, input logic [7:0] hwd,
                          input logic hlock);
        core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
        host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
        host_lock = hlock;
    endtask

    task automatic idle();
        set_in(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, 0);
    endtask

    task automatic check_all(input string tag, input logic ecg, input logic ehg, input logic emwe,
                             input logic [15:0] eaddr,
                             input logic ecrv, input logic ecerr, input logic [7:0] ecrd,
                             input logic ehrv, input logic eherr, input logic [7:0] ehrd);
        chk({tag, ".core_gnt"}, 32'(core_gnt), 32'(ecg));
        chk({tag, ".host_gnt"}, 32'(host_gnt), 32'(ehg));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(emwe));
        if (ecg || ehg) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(eaddr));
        chk({tag, ".core_rvalid"}, 32'(core_rvalid), 32'(ecrv));
        chk({tag, ".core_err"}, 32'(core_err), 32'(ecerr));
        chk({tag, ".core_rdata"}, 32'(core_rdata), 32'(ecrd));
        chk({tag, ".host_rvalid"}, 32'(host_rvalid), 32'(ehrv));
        chk({tag, ".host_err"}, 32'(host_err), 32'(eherr));
        chk({tag, ".host_rdata"}, 32'(host_rdata), 32'(ehrd));
    endtask

    typedef struct {
        logic        creq, cwe;
        logic [15:0] caddr;
        logic [7:0]  cwd;
        logic        hreq, hwe;
        logic [15:0] haddr;
        logic [7:0]  hwd;
        logic        hlock;
        logic        e_cg, e_hg, e_mwe, e_crv, e_cerr;
        logic [7:0]  e_crd;
        logic        e_hrv, e_herr;
        logic [7:0]  e_hrd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic creq, input logic cwe, input logic [15:0] caddr, input logic [7:0] cwd,
                                input logic hreq, input logic hwe, input logic [15:0] haddr, input logic [7:0] hwd,
                                input logic hlock, input logic ecg, input logic ehg, input logic emwe,
                                input logic ecrv, input logic ecerr, input logic [7:0] ecrd,
                                input logic ehrv, input logic eherr, input logic [7:0] ehrd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd; v.hlock = hlock;
        v.e_cg = ecg; v.e_hg = ehg; v.e_mwe = emwe;
        v.e_crv = ecrv; v.e_cerr = ecerr; v.e_crd = ecrd;
        v.e_hrv = ehrv; v.e_herr = eherr; v.e_hrd = ehrd;
        return v;
    endfunction

    // Reference model state for the randomized run.
    int       m_mode;      // 0 round-robin, 1 host locked, 2 forced core slot
    bit       m_last_host;
    int       m_run;
    bit       pc_rv, pc_err, ph_rv, ph_err;
    logic [7:0] pc_d, ph_d;
    bit [7:0] ref_delta [0:65535];
    int       m_cg_cnt, m_hg_cnt;

    function automatic logic [15:0] pick_addr();
        int r;
        r = int'($urandom % 10);
        if (r < 8) return 16'h0180 + 16'($urandom % 8);
        if (r == 8) return 16'h0200 + 16'($urandom % 4);
        return 16'hFFFF;
    endfunction

    initial begin
        int cg_tot, hg_tot;
        logic hl;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        check_all("reset", 0, 0, 0, 16'h0, 0, 0, 8'h00, 0, 0, 8'h00);
        chk("reset.core_gnt_cnt", 32'(core_gnt_cnt), 32'd0);
        chk("reset.host_gnt_cnt", 32'(host_gnt_cnt), 32'd0);

        //              creq cwe caddr    cwd   hreq hwe haddr    hwd   lk  cg hg we crv ce crd          hrv he hrd
        vecs.push_back(mk(1, 0, 16'h0000, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 1, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 16'h0000, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 0, 0, 0, 1, 0, 8'h2B,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0,  0, 1, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0,  0, 0, 1, 0, 1, 0, init_val('h10), 0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0,  0, 1, 0, 0, 0, 0, 8'h00,          1, 0, init_val('h20)));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0,  0, 0, 1, 0, 1, 0, init_val('h10), 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 16'h0000, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 0, 0, 0, 0, 0, 8'h00,          1, 0, init_val('h20)));
        vecs.push_back(mk(0, 0, 16'h0000, 8'h0, 1, 1, 16'h0100, 8'hFF, 0, 0, 1, 1, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0100, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 1, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 16'h0000, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 0, 0, 0, 1, 0, 8'hFF,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0200, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 1, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 16'h0000, 8'h0, 1, 1, 16'hFFFF, 8'hAA, 0, 0, 1, 0, 1, 1, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 16'h0000, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 0, 0, 0, 0, 0, 8'h00,          0, 1, 8'h00));
        // host lock burst against a persistent core request
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h11, 1, 1, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h11, 1, 0, 1, 1, 1, 0, init_val('h10), 0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h11, 1, 0, 1, 1, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h11, 1, 0, 1, 1, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h11, 1, 0, 1, 1, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h11, 1, 0, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h11, 1, 1, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h11, 1, 0, 1, 1, 1, 0, init_val('h10), 0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h5C, 0, 1, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0010, 8'h0, 1, 1, 16'h0040, 8'h5C, 0, 0, 1, 1, 1, 0, init_val('h10), 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 16'h0000, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 0, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0040, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 1, 0, 0, 0, 0, 8'h00,          0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 16'h0000, 8'h0, 0, 0, 16'h0000, 8'h0,  0, 0, 0, 0, 1, 0, 8'h5C,          0, 0, 8'h00));

        cg_tot = 0;
        hg_tot = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            set_in(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                   vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hwd, vecs[i].hlock);
            #3;
            check_all($sformatf("vec%0d", i), vecs[i].e_cg, vecs[i].e_hg, vecs[i].e_mwe,
                      vecs[i].e_hg ? vecs[i].haddr : vecs[i].caddr,
                      vecs[i].e_crv, vecs[i].e_cerr, vecs[i].e_crd,
                      vecs[i].e_hrv, vecs[i].e_herr, vecs[i].e_hrd);
            cg_tot += int'(vecs[i].e_cg);
            hg_tot += int'(vecs[i].e_hg);
        end
        @(posedge clk);
        #1 idle();
        #3;
        chk("oor.mem_unchanged", 32'(delta[16'hFFFF]), 32'd0);
`ifdef MEM_ARB_STATS_EN
        chk("stats.core_after_table", 32'(core_gnt_cnt), 32'(cg_tot));
        chk("stats.host_after_table", 32'(host_gnt_cnt), 32'(hg_tot));
`else
        chk("stats.core_after_table", 32'(core_gnt_cnt), 32'd0);
        chk("stats.host_after_table", 32'(host_gnt_cnt), 32'd0);
`endif

        // Reset lands on a granted read while the host holds the lock.
        @(posedge clk);
        #1 set_in(0, 0, 16'h0, 8'h0, 1, 1, 16'h0040, 8'h33, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        set_in(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0, 1);
        #3 chk("rst.inflight_host_gnt", 32'(host_gnt), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        set_in(1, 0, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0, 0);
        #3;
        chk("rst.host_rvalid_dropped", 32'(host_rvalid), 32'd0);
        chk("rst.host_rdata", 32'(host_rdata), 32'd0);
        chk("rst.core_wins_first", 32'(core_gnt), 32'd1);
        chk("rst.host_waits", 32'(host_gnt), 32'd0);
        chk("rst.core_cnt_clear", 32'(core_gnt_cnt), 32'd0);
        chk("rst.host_cnt_clear", 32'(host_gnt_cnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 set_in(0, 0, 16'h0, 8'h0, 1, 0, 16'h0020, 8'h0, 0);
            #3;
            chk($sformatf("post_rst%0d.host_gnt", k), 32'(host_gnt), 32'd1);
            chk($sformatf("post_rst%0d.host_rvalid", k), 32'(host_rvalid), 32'(k > 0));
            chk($sformatf("post_rst%0d.host_rdata", k), 32'(host_rdata), (k > 0) ? 32'(init_val('h20)) : 32'd0);
        end
        @(posedge clk);
        #1 idle();
        #3;
`ifdef MEM_ARB_STATS_EN
        chk("stats.core_six", 32'(core_gnt_cnt), 32'd1);
        chk("stats.host_six", 32'(host_gnt_cnt), 32'd5);
`else
        chk("stats.core_six", 32'(core_gnt_cnt), 32'd0);
        chk("stats.host_six", 32'(host_gnt_cnt), 32'd0);
`endif

        // Randomized run against the reference model.
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        m_mode = 0; m_last_host = 1'b1; m_run = 0;
        pc_rv = 0; pc_err = 0; pc_d = 8'h0; ph_rv = 0; ph_err = 0; ph_d = 8'h0;
        m_cg_cnt = 0; m_hg_cnt = 0;
        hl = 1'b0;
        for (int k = 0; k < 400; k++) begin
            logic creq, cwe, hreq, hwe, eg_c, eg_h, rr, emwe;
            logic [15:0] ca, ha, ea;
            logic [7:0] cwd, hwd;
            string tag;
            creq = ($urandom % 10) < 7;
            cwe  = 1'($urandom % 2);
            ca   = pick_addr();
            cwd  = 8'($urandom);
            hreq = ($urandom % 10) < 7;
            hwe  = 1'($urandom % 2);
            ha   = pick_addr();
            hwd  = 8'($urandom);
            if (($urandom % 8) == 0) hl = ~hl;
            set_in(creq, cwe, ca, cwd, hreq, hwe, ha, hwd, hl);
            #3;

            eg_c = 0;
            eg_h = 0;
            rr = (m_mode == 0) || (m_mode == 1 && !hl);
            if (rr) begin
                if (creq && hreq) begin
                    if (m_last_host) eg_c = 1; else eg_h = 1;
                end else begin
                    eg_c = creq;
                    eg_h = hreq;
                end
            end else if (m_mode == 1) begin
                eg_h = hreq && !(m_run == MAXL && creq);
            end else begin
                eg_c = creq;
            end
            emwe = (eg_c && cwe && inr(ca)) || (eg_h && hwe && inr(ha));
            ea = eg_h ? ha : ca;
            tag = $sformatf("rnd%0d", k);
            check_all(tag, eg_c, eg_h, emwe, ea, pc_rv, pc_err, pc_d, ph_rv, ph_err, ph_d);

            if (rr) begin
                if (creq && hreq) m_last_host = eg_h;
                if (eg_h && hl) begin
                    m_mode = 1;
                    m_run = 1;
                end else begin
                    m_mode = 0;
                end
            end else if (m_mode == 1) begin
                if (m_run == MAXL && creq) m_mode = 2;
                else if (m_run < MAXL) m_run++;
            end else begin
                m_mode = hl ? 1 : 0;
                m_run = 0;
            end

            pc_rv  = eg_c && !cwe;
            pc_err = eg_c && !inr(ca);
            pc_d   = (pc_rv && inr(ca)) ? (init_val(int'(ca)) ^ ref_delta[ca]) : 8'h00;
            ph_rv  = eg_h && !hwe;
            ph_err = eg_h && !inr(ha);
            ph_d   = (ph_rv && inr(ha)) ? (init_val(int'(ha)) ^ ref_delta[ha]) : 8'h00;
            if (eg_c && cwe && inr(ca)) ref_delta[ca] = cwd ^ init_val(int'(ca));
            if (eg_h && hwe && inr(ha)) ref_delta[ha] = hwd ^ init_val(int'(ha));
            m_cg_cnt += int'(eg_c);
            m_hg_cnt += int'(eg_h);

            @(posedge clk);
            #1;
        end
        idle();
        #3;
        chk("rnd.final_core_rvalid", 32'(core_rvalid), 32'(pc_rv));
        chk("rnd.final_host_rvalid", 32'(host_rvalid), 32'(ph_rv));
`ifdef MEM_ARB_STATS_EN
        chk("rnd.core_gnt_cnt", 32'(core_gnt_cnt), 32'(m_cg_cnt));
        chk("rnd.host_gnt_cnt", 32'(host_gnt_cnt), 32'(m_hg_cnt));
`else
        chk("rnd.core_gnt_cnt", 32'(core_gnt_cnt), 32'd0);
        chk("rnd.host_gnt_cnt", 32'(host_gnt_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
